// File: rtl/control_unit.sv
// RV32I main decoder for the decode stage. The instruction fields are decoded
// combinationally and the control word is captured in the ID/EX register,
// which can be held (stall) or cleared to a NOP (flush).

typedef enum logic [6:0] {
   rTypeInstruction       = 7'b0110011,
   iTypeInstruction       = 7'b0010011,
   iTypeInstruction_LOAD  = 7'b0000011,
   sTypeInstruction       = 7'b0100011,
   bTypeInstruction       = 7'b1100011,
   jTypeInstruction       = 7'b1101111,
   iTypeInstruction_JALR  = 7'b1100111,
   uTypeInstruction_LUI   = 7'b0110111,
   uTypeInstruction_AUIPC = 7'b0010111
} opcode_t;

typedef enum logic [3:0] {
   addALU  = 4'd0,
   subALU  = 4'd1,
   sllALU  = 4'd2,
   sltALU  = 4'd3,
   sltuALU = 4'd4,
   xorALU  = 4'd5,
   srlALU  = 4'd6,
   sraALU  = 4'd7,
   orALU   = 4'd8,
   andALU  = 4'd9,
   luiALU  = 4'd10
} ALU_operation_t;

typedef struct packed {
   ALU_operation_t op;
   logic           useImm;
   logic           readMem;
   logic           writeMem;
   logic           writeReg;
   logic [1:0]     wbSel;
   logic           branch;
   logic           pcA;
   logic           illegal;
} ctrl_t;

module control_unit (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           stall,
   input  logic           flush,
   input  logic [6:0]     opcode,
   input  logic [2:0]     funct3,
   input  logic [6:0]     funct7,
   output ALU_operation_t operationALU,
   output logic           useImmediate,
   output logic           readMemory,
   output logic           writeMemory,
   output logic           writeRegister,
   output logic [1:0]     writebackItem,
   output logic           branch,
   output logic           pcInputA,
   output logic           illegal
);

   ctrl_t          decoded;
   ctrl_t          ctrl_d;
   ctrl_t          ctrl_q;
   ALU_operation_t baseOp;

   // ALU operation implied by funct3 alone (funct7 modifiers applied later)
   always_comb begin
      baseOp = addALU;
      case (funct3)
         3'd0: baseOp = addALU;
         3'd1: baseOp = sllALU;
         3'd2: baseOp = sltALU;
         3'd3: baseOp = sltuALU;
         3'd4: baseOp = xorALU;
         3'd5: baseOp = srlALU;
         3'd6: baseOp = orALU;
         3'd7: baseOp = andALU;
         default: baseOp = addALU;
      endcase
   end

   // Main decode; anything unsupported leaves NOP controls with illegal set
   always_comb begin
      decoded    = '0;
      decoded.op = addALU;
      case (opcode)
         rTypeInstruction: begin
            if (funct7 == 7'h00) begin
               decoded.writeReg = 1'b1;
               decoded.op       = baseOp;
            end else if (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)) begin
               decoded.writeReg = 1'b1;
               decoded.op       = (funct3 == 3'd0) ? subALU : sraALU;
            end else begin
               decoded.illegal = 1'b1;
            end
         end
         iTypeInstruction: begin
            if (funct3 == 3'd1 && funct7 != 7'h00) begin
               decoded.illegal = 1'b1;
            end else if (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20) begin
               decoded.illegal = 1'b1;
            end else begin
               decoded.useImm   = 1'b1;
               decoded.writeReg = 1'b1;
               decoded.op       = (funct3 == 3'd5 && funct7 == 7'h20) ? sraALU : baseOp;
            end
         end
         iTypeInstruction_LOAD: begin
            decoded.useImm   = 1'b1;
            decoded.readMem  = 1'b1;
            decoded.writeReg = 1'b1;
            decoded.wbSel    = 2'd1;
         end
         sTypeInstruction: begin
            decoded.useImm   = 1'b1;
            decoded.writeMem = 1'b1;
         end
         bTypeInstruction: begin
            case (funct3)
               3'd0, 3'd1: begin
                  decoded.branch = 1'b1;
                  decoded.op     = subALU;
               end
               3'd4, 3'd5: begin
                  decoded.branch = 1'b1;
                  decoded.op     = sltALU;
               end
               3'd6, 3'd7: begin
                  decoded.branch = 1'b1;
                  decoded.op     = sltuALU;
               end
               default: decoded.illegal = 1'b1;
            endcase
         end
         jTypeInstruction: begin
            decoded.useImm   = 1'b1;
            decoded.writeReg = 1'b1;
            decoded.wbSel    = 2'd2;
            decoded.branch   = 1'b1;
            decoded.pcA      = 1'b1;
         end
         iTypeInstruction_JALR: begin
            decoded.useImm   = 1'b1;
            decoded.writeReg = 1'b1;
            decoded.wbSel    = 2'd2;
            decoded.branch   = 1'b1;
         end
         uTypeInstruction_LUI: begin
            decoded.useImm   = 1'b1;
            decoded.writeReg = 1'b1;
            decoded.op       = luiALU;
         end
         uTypeInstruction_AUIPC: begin
            decoded.useImm   = 1'b1;
            decoded.writeReg = 1'b1;
         end
         default: decoded.illegal = 1'b1;
      endcase
   end

   // Pipeline register next value: flush beats stall beats a fresh decode
   always_comb begin
      ctrl_d    = '0;
      ctrl_d.op = addALU;
      if (flush) begin
         ctrl_d    = '0;
         ctrl_d.op = addALU;
      end else if (stall) begin
         ctrl_d = ctrl_q;
      end else begin
         ctrl_d = decoded;
      end
   end

   // ID/EX control register, cleared to NOP on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q    <= '0;
         ctrl_q.op <= addALU;
      end else begin
         ctrl_q <= ctrl_d;
      end
   end

   assign operationALU  = ctrl_q.op;
   assign useImmediate  = ctrl_q.useImm;
   assign readMemory    = ctrl_q.readMem;
   assign writeMemory   = ctrl_q.writeMem;
   assign writeRegister = ctrl_q.writeReg;
   assign writebackItem = ctrl_q.wbSel;
   assign branch        = ctrl_q.branch;
   assign pcInputA      = ctrl_q.pcA;
   assign illegal       = ctrl_q.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: directed cases followed by random instructions
// with random stall/flush, compared against a table-driven reference model.

module tb_control_unit;

   // ALU operation codes as seen on the operationALU port
   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_SLL  = 4'd2;
   localparam logic [3:0] OP_SLT  = 4'd3;
   localparam logic [3:0] OP_SLTU = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_OR   = 4'd8;
   localparam logic [3:0] OP_AND  = 4'd9;
   localparam logic [3:0] OP_LUI  = 4'd10;

   localparam logic [6:0] OPC_R     = 7'b0110011;
   localparam logic [6:0] OPC_I     = 7'b0010011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_B     = 7'b1100011;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   // Expected word layout: {op[3:0], uImm, rdM, wrM, wrR, wb[1:0], br, pcA, illegal}
   localparam logic [12:0] NOP = 13'h0000;

   logic       clk;
   logic       rst_n;
   logic       stall;
   logic       flush;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [3:0] operationALU;
   logic       useImmediate;
   logic       readMemory;
   logic       writeMemory;
   logic       writeRegister;
   logic [1:0] writebackItem;
   logic       branch;
   logic       pcInputA;
   logic       illegal;

   int          checks;
   int          errors;
   logic [12:0] expected;

   control_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .flush         (flush),
      .opcode        (opcode),
      .funct3        (funct3),
      .funct7        (funct7),
      .operationALU  (operationALU),
      .useImmediate  (useImmediate),
      .readMemory    (readMemory),
      .writeMemory   (writeMemory),
      .writeRegister (writeRegister),
      .writebackItem (writebackItem),
      .branch        (branch),
      .pcInputA      (pcInputA),
      .illegal       (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [12:0] pack(input logic [3:0] op, input logic [7:0] flags);
      return {op, flags, 1'b0};
   endfunction

   function automatic logic [12:0] observed();
      return {operationALU, useImmediate, readMemory, writeMemory, writeRegister,
              writebackItem, branch, pcInputA, illegal};
   endfunction

   // Reference decode written straight from the instruction table
   function automatic logic [12:0] model(input logic [6:0] opc, input logic [2:0] f3,
                                         input logic [6:0] f7);
      logic [3:0] aluByF3 [8];
      logic [3:0] brByF3  [8];
      logic       brOk    [8];
      logic [12:0] illegalWord;
      aluByF3 = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND};
      brByF3  = '{OP_SUB, OP_SUB, OP_ADD, OP_ADD, OP_SLT, OP_SLT, OP_SLTU, OP_SLTU};
      brOk    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      illegalWord = 13'h0001;
      if (opc == OPC_R) begin
         if (f7 == 7'h00) return pack(aluByF3[f3], 8'b0001_0000);
         if (f7 == 7'h20 && f3 == 3'd0) return pack(OP_SUB, 8'b0001_0000);
         if (f7 == 7'h20 && f3 == 3'd5) return pack(OP_SRA, 8'b0001_0000);
         return illegalWord;
      end
      if (opc == OPC_I) begin
         if (f3 == 3'd1 && f7 != 7'h00) return illegalWord;
         if (f3 == 3'd5 && f7 == 7'h20) return pack(OP_SRA, 8'b1001_0000);
         if (f3 == 3'd5 && f7 != 7'h00) return illegalWord;
         return pack(aluByF3[f3], 8'b1001_0000);
      end
      if (opc == OPC_LOAD)  return pack(OP_ADD, 8'b1101_0100);
      if (opc == OPC_STORE) return pack(OP_ADD, 8'b1010_0000);
      if (opc == OPC_B) begin
         if (!brOk[f3]) return illegalWord;
         return pack(brByF3[f3], 8'b0000_0010);
      end
      if (opc == OPC_JAL)   return pack(OP_ADD, 8'b1001_1011);
      if (opc == OPC_JALR)  return pack(OP_ADD, 8'b1001_1010);
      if (opc == OPC_LUI)   return pack(OP_LUI, 8'b1001_0000);
      if (opc == OPC_AUIPC) return pack(OP_ADD, 8'b1001_0000);
      return illegalWord;
   endfunction

   task automatic checkOutput(input string tag, input logic [12:0] obs, input logic [12:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one instruction, clock it in, update the model and compare
   task automatic applyStimulus(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                                input logic [6:0] f7, input logic st, input logic fl);
      @(negedge clk);
      opcode = opc;
      funct3 = f3;
      funct7 = f7;
      stall  = st;
      flush  = fl;
      @(posedge clk);
      if (fl)       expected = NOP;
      else if (!st) expected = model(opc, f3, f7);
      #1;
      checkOutput(tag, observed(), expected);
   endtask

   initial begin
      logic [6:0] opcList [9];
      logic [6:0] rOpc;
      logic [6:0] rF7;
      checks   = 0;
      errors   = 0;
      expected = NOP;
      opcList  = '{OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_B, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC};
      rst_n  = 1'b0;
      stall  = 1'b0;
      flush  = 1'b0;
      opcode = OPC_R;
      funct3 = 3'd0;
      funct7 = 7'h00;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset", observed(), NOP);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus("add",      OPC_R,     3'd0, 7'h00, 1'b0, 1'b0);
      applyStimulus("sub",      OPC_R,     3'd0, 7'h20, 1'b0, 1'b0);
      applyStimulus("lw",       OPC_LOAD,  3'd2, 7'h00, 1'b0, 1'b0);
      applyStimulus("sw",       OPC_STORE, 3'd2, 7'h00, 1'b0, 1'b0);
      applyStimulus("beq",      OPC_B,     3'd0, 7'h7f, 1'b0, 1'b0);
      applyStimulus("bltu",     OPC_B,     3'd6, 7'h00, 1'b0, 1'b0);
      applyStimulus("bBad",     OPC_B,     3'd2, 7'h00, 1'b0, 1'b0);
      applyStimulus("jal",      OPC_JAL,   3'd5, 7'h33, 1'b0, 1'b0);
      applyStimulus("jalr",     OPC_JALR,  3'd0, 7'h00, 1'b0, 1'b0);
      applyStimulus("lui",      OPC_LUI,   3'd3, 7'h20, 1'b0, 1'b0);
      applyStimulus("auipc",    OPC_AUIPC, 3'd7, 7'h01, 1'b0, 1'b0);
      applyStimulus("addiF7",   OPC_I,     3'd0, 7'h20, 1'b0, 1'b0);
      applyStimulus("srai",     OPC_I,     3'd5, 7'h20, 1'b0, 1'b0);
      applyStimulus("slliBad",  OPC_I,     3'd1, 7'h20, 1'b0, 1'b0);
      applyStimulus("rBadF7",   OPC_R,     3'd1, 7'h20, 1'b0, 1'b0);
      applyStimulus("badOpc",   7'h7f,     3'd0, 7'h00, 1'b0, 1'b0);
      applyStimulus("addAgain", OPC_R,     3'd0, 7'h00, 1'b0, 1'b0);
      applyStimulus("stallHold",OPC_LUI,   3'd0, 7'h00, 1'b1, 1'b0);
      applyStimulus("flushWins",OPC_LUI,   3'd0, 7'h00, 1'b1, 1'b1);
      applyStimulus("afterFl",  OPC_JAL,   3'd0, 7'h00, 1'b0, 1'b0);

      // Reset asserted between edges must clear the outputs immediately
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      expected = NOP;
      checkOutput("asyncRst", observed(), NOP);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0) rOpc = 7'($urandom);
         else rOpc = opcList[$urandom_range(0, 8)];
         case ($urandom_range(0, 3))
            0, 1:    rF7 = 7'h00;
            2:       rF7 = 7'h20;
            default: rF7 = 7'($urandom);
         endcase
         applyStimulus("random", rOpc, 3'($urandom), rF7,
                       ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
